// File: rtl/pin_entry_pkg.sv
// -----------------------------------------------------------------------------
// pin_entry_pkg
// Shared definitions for the PIN entry front end: keypad code points and the
// controller state encoding.
// -----------------------------------------------------------------------------
package pin_entry_pkg;

   // Keypad codes 0-9 are digits. The codes below are function keys.
   // Codes 4'hD-4'hF are reserved. They count as activity but are otherwise ignored.
   localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
   localparam logic [3:0] KEY_BKSP      = 4'hA;
   localparam logic [3:0] KEY_ENTER     = 4'hB;
   localparam logic [3:0] KEY_CANCEL    = 4'hC;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      PRESENT = 3'd2,
      DONE    = 3'd3,
      LOCKED  = 3'd4
   } state_e;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= KEY_DIGIT_MAX);
   endfunction

endpackage

// File: rtl/inactivity_timer.sv
// -----------------------------------------------------------------------------
// inactivity_timer
// Counts idle cycles while enabled. It saturates at TIMEOUT_CYCLES-1 and flags
// expiry at that count.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   clear    in   synchronous clear. It has priority over counting.
//   enable   in   count one per cycle while high.
//   expired  out  high while enabled and the count equals TIMEOUT_CYCLES-1.
// -----------------------------------------------------------------------------
module inactivity_timer #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expired = enable && (count_q == LAST);

   // The count holds once it reaches LAST. The owner acts on expiry that
   // cycle and then clears the timer.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pin_entry_ctrl.sv
// -----------------------------------------------------------------------------
// pin_entry_ctrl
// Keypad front end for the ATM authentication FSM. It collects four PIN digits
// with backspace, enter and cancel. It then presents the frozen PIN with a
// valid flag, waits for the accept or reject verdict, and enforces both an
// inactivity timeout and a wrong-PIN attempt limit that retains the card.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   card_present    in   level: a card is in the slot
//   key_valid       in   one-cycle keypad strobe
//   key_code[3:0]   in   0-9 digit, A bksp, B enter, C cancel, D-F ignored
//   pin_accept      in   verdict pulse: PIN matched
//   pin_reject      in   verdict pulse: PIN mismatch. It wins over accept.
//   pin0..pin3[3:0] out  captured digits. pin0 is the first digit typed.
//   pin_valid       out  PIN frozen and ready for compare
//   digit_count[2:0]out  digits currently held (0..4)
//   attempts_left   out  remaining tries
//   timeout         out  pulse on inactivity abort
//   eject_card      out  pulse requesting card return
//   card_locked     out  level: card retained until reset
// All outputs are registered.
// -----------------------------------------------------------------------------
module pin_entry_ctrl
   import pin_entry_pkg::*;
#(
   parameter int PIN_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       card_present,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       pin_accept,
   input  logic       pin_reject,
   output logic [3:0] pin0,
   output logic [3:0] pin1,
   output logic [3:0] pin2,
   output logic [3:0] pin3,
   output logic       pin_valid,
   output logic [2:0] digit_count,
   output logic [1:0] attempts_left,
   output logic       timeout,
   output logic       eject_card,
   output logic       card_locked
);

   localparam logic [2:0] FULL_COUNT = 3'(PIN_DIGITS);
   localparam logic [1:0] MAX_ATT    = 2'(MAX_ATTEMPTS);

   state_e     state_q, state_d;
   logic [3:0] pin_q [4];
   logic [3:0] pin_d [4];
   logic [2:0] cnt_q, cnt_d;
   logic       valid_q, valid_d;
   logic [1:0] att_q, att_d;
   logic       timeout_q, timeout_d;
   logic       eject_q, eject_d;
   logic       locked_q, locked_d;

   logic       timer_clear;
   logic       timer_enable;
   logic       timer_expired;
   logic [1:0] wr_idx;
   logic [1:0] bk_idx;
   logic [1:0] att_dec;

   // The timer runs only while collecting. Any keypad strobe restarts it.
   // This includes ignored codes.
   assign timer_enable = (state_q == COLLECT);
   assign timer_clear  = (state_q != COLLECT) || key_valid;

   inactivity_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   always_comb begin
      state_d   = state_q;
      pin_d     = pin_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      att_d     = att_q;
      timeout_d = 1'b0;
      eject_d   = 1'b0;
      locked_d  = locked_q;

      wr_idx  = cnt_q[1:0];
      bk_idx  = 2'(cnt_q - 3'd1);
      att_dec = att_q - 2'd1;

      case (state_q)
         IDLE: begin
            if (card_present) begin
               state_d = COLLECT;
               pin_d   = '{default: 4'h0};
               cnt_d   = 3'd0;
               valid_d = 1'b0;
               att_d   = MAX_ATT;
            end
         end

         COLLECT: begin
            if (!card_present) begin
               // The card was pulled out, so there is nothing to eject.
               state_d = IDLE;
               pin_d   = '{default: 4'h0};
               cnt_d   = 3'd0;
            end else if (key_valid && (key_code == KEY_CANCEL)) begin
               state_d = IDLE;
               eject_d = 1'b1;
               pin_d   = '{default: 4'h0};
               cnt_d   = 3'd0;
            end else if (key_valid) begin
               // A key in the same cycle as expiry wins. The timer clears on the key.
               if (is_digit(key_code)) begin
                  if (cnt_q < FULL_COUNT) begin
                     pin_d[wr_idx] = key_code;
                     cnt_d         = cnt_q + 3'd1;
                  end
               end else if (key_code == KEY_BKSP) begin
                  if (cnt_q != 3'd0) begin
                     pin_d[bk_idx] = 4'h0;
                     cnt_d         = cnt_q - 3'd1;
                  end
               end else if (key_code == KEY_ENTER) begin
                  if (cnt_q == FULL_COUNT) begin
                     state_d = PRESENT;
                     valid_d = 1'b1;
                  end
               end
            end else if (timer_expired) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               eject_d   = 1'b1;
               pin_d     = '{default: 4'h0};
               cnt_d     = 3'd0;
            end
         end

         PRESENT: begin
            if (!card_present) begin
               state_d = IDLE;
               valid_d = 1'b0;
               pin_d   = '{default: 4'h0};
               cnt_d   = 3'd0;
            end else if (pin_reject) begin
               att_d   = att_dec;
               valid_d = 1'b0;
               if (att_dec == 2'd0) begin
                  // The card is retained, so no eject is requested.
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end else begin
                  state_d = COLLECT;
                  pin_d   = '{default: 4'h0};
                  cnt_d   = 3'd0;
               end
            end else if (pin_accept) begin
               state_d = DONE;
               valid_d = 1'b0;
            end
         end

         DONE: begin
            if (!card_present) begin
               state_d = IDLE;
            end
         end

         LOCKED: begin
            // Only reset leaves this state.
            locked_d = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         for (int i = 0; i < 4; i++) begin
            pin_q[i] <= 4'h0;
         end
         cnt_q     <= 3'd0;
         valid_q   <= 1'b0;
         att_q     <= MAX_ATT;
         timeout_q <= 1'b0;
         eject_q   <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pin_q     <= pin_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         att_q     <= att_d;
         timeout_q <= timeout_d;
         eject_q   <= eject_d;
         locked_q  <= locked_d;
      end
   end

   assign pin0          = pin_q[0];
   assign pin1          = pin_q[1];
   assign pin2          = pin_q[2];
   assign pin3          = pin_q[3];
   assign pin_valid     = valid_q;
   assign digit_count   = cnt_q;
   assign attempts_left = att_q;
   assign timeout       = timeout_q;
   assign eject_card    = eject_q;
   assign card_locked   = locked_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
module tb_pin_entry_ctrl;

   localparam logic [3:0] K_BK = 4'hA;
   localparam logic [3:0] K_EN = 4'hB;
   localparam logic [3:0] K_CN = 4'hC;

   logic       clk;
   logic       rst;
   logic       card_present;
   logic       key_valid;
   logic [3:0] key_code;
   logic       pin_accept;
   logic       pin_reject;
   logic [3:0] pin0, pin1, pin2, pin3;
   logic       pin_valid;
   logic [2:0] digit_count;
   logic [1:0] attempts_left;
   logic       timeout;
   logic       eject_card;
   logic       card_locked;

   int n_tests = 0;
   int n_fail  = 0;

   pin_entry_ctrl #(
      .PIN_DIGITS     (4),
      .TIMEOUT_CYCLES (20),
      .MAX_ATTEMPTS   (3),
      .CNT_W          (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .card_present  (card_present),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .pin_accept    (pin_accept),
      .pin_reject    (pin_reject),
      .pin0          (pin0),
      .pin1          (pin1),
      .pin2          (pin2),
      .pin3          (pin3),
      .pin_valid     (pin_valid),
      .digit_count   (digit_count),
      .attempts_left (attempts_left),
      .timeout       (timeout),
      .eject_card    (eject_card),
      .card_locked   (card_locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus plus the expected outputs one edge later. The expected pulses
   // (timeout and eject) are zero throughout the table.
   typedef struct {
      logic        card;
      logic        kv;
      logic [3:0]  code;
      logic        acc;
      logic        rej;
      logic [15:0] pins;
      logic [2:0]  cnt;
      logic        vld;
      logic [1:0]  att;
      logic        lk;
   } vec_t;

   vec_t vecs[$];

   localparam logic [24:0] RESET_OUTS = {16'h0000, 3'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};

   function automatic logic [24:0] outs();
      return {pin0, pin1, pin2, pin3, digit_count, pin_valid, attempts_left,
              timeout, eject_card, card_locked};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic card, input logic kv, input logic [3:0] code,
                      input logic acc, input logic rej, input logic [15:0] pins,
                      input logic [2:0] cnt, input logic vld, input logic [1:0] att,
                      input logic lk);
      vec_t v;
      v.card = card; v.kv = kv; v.code = code; v.acc = acc; v.rej = rej;
      v.pins = pins; v.cnt = cnt; v.vld = vld; v.att = att; v.lk = lk;
      vecs.push_back(v);
   endtask

   task automatic step(input logic card, input logic kv, input logic [3:0] code,
                       input logic acc, input logic rej);
      card_present = card;
      key_valid    = kv;
      key_code     = code;
      pin_accept   = acc;
      pin_reject   = rej;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      card_present = 1'b0; key_valid = 1'b0; key_code = 4'h0;
      pin_accept = 1'b0; pin_reject = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic key(input logic [3:0] code);
      step(1'b1, 1'b1, code, 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      int first_pulse;
      int early;
      logic saw_ej;

      // ---------------- table: happy path, editing, retry and lock -------
      //   card kv code  acc rej   pins     cnt vld att lk
      add(1, 0, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 2'd3, 0); // IDLE -> COLLECT
      add(1, 1, 4'h1, 0, 0, 16'h1000, 3'd1, 0, 2'd3, 0);
      add(1, 1, 4'h2, 0, 0, 16'h1200, 3'd2, 0, 2'd3, 0);
      add(1, 1, 4'h3, 0, 0, 16'h1230, 3'd3, 0, 2'd3, 0);
      add(1, 1, 4'h4, 0, 0, 16'h1234, 3'd4, 0, 2'd3, 0);
      add(1, 1, 4'h0, 0, 0, 16'h1234, 3'd4, 0, 2'd3, 0); // fifth digit dropped
      add(1, 1, 4'hE, 0, 0, 16'h1234, 3'd4, 0, 2'd3, 0); // ignored code
      add(1, 1, K_EN, 0, 0, 16'h1234, 3'd4, 1, 2'd3, 0); // PRESENT
      add(1, 1, 4'h5, 0, 0, 16'h1234, 3'd4, 1, 2'd3, 0); // keys ignored
      add(1, 0, 4'h0, 1, 0, 16'h1234, 3'd4, 0, 2'd3, 0); // accept -> DONE
      add(1, 1, 4'h1, 0, 0, 16'h1234, 3'd4, 0, 2'd3, 0); // DONE ignores keys
      add(0, 0, 4'h0, 0, 0, 16'h1234, 3'd4, 0, 2'd3, 0); // -> IDLE
      add(1, 0, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 2'd3, 0); // new card
      add(1, 1, 4'h5, 0, 0, 16'h5000, 3'd1, 0, 2'd3, 0);
      add(1, 1, 4'h6, 0, 0, 16'h5600, 3'd2, 0, 2'd3, 0);
      add(1, 1, K_BK, 0, 0, 16'h5000, 3'd1, 0, 2'd3, 0);
      add(1, 1, 4'h7, 0, 0, 16'h5700, 3'd2, 0, 2'd3, 0);
      add(1, 1, 4'h8, 0, 0, 16'h5780, 3'd3, 0, 2'd3, 0);
      add(1, 1, K_EN, 0, 0, 16'h5780, 3'd3, 0, 2'd3, 0); // enter with 3 digits ignored
      add(1, 1, 4'h9, 0, 0, 16'h5789, 3'd4, 0, 2'd3, 0);
      add(1, 1, K_EN, 0, 0, 16'h5789, 3'd4, 1, 2'd3, 0);
      add(1, 0, 4'h0, 1, 1, 16'h0000, 3'd0, 0, 2'd2, 0); // accept+reject = reject
      add(1, 1, K_BK, 0, 0, 16'h0000, 3'd0, 0, 2'd2, 0); // bksp at 0
      add(1, 0, 4'h0, 1, 1, 16'h0000, 3'd0, 0, 2'd2, 0); // verdicts outside PRESENT
      add(1, 1, 4'h9, 0, 0, 16'h9000, 3'd1, 0, 2'd2, 0);
      add(1, 1, 4'h9, 0, 0, 16'h9900, 3'd2, 0, 2'd2, 0);
      add(1, 1, 4'h9, 0, 0, 16'h9990, 3'd3, 0, 2'd2, 0);
      add(1, 1, 4'h9, 0, 0, 16'h9999, 3'd4, 0, 2'd2, 0);
      add(1, 1, K_EN, 0, 0, 16'h9999, 3'd4, 1, 2'd2, 0);
      add(1, 0, 4'h0, 0, 1, 16'h0000, 3'd0, 0, 2'd1, 0); // second reject
      add(1, 1, 4'h9, 0, 0, 16'h9000, 3'd1, 0, 2'd1, 0);
      add(1, 1, 4'h9, 0, 0, 16'h9900, 3'd2, 0, 2'd1, 0);
      add(1, 1, 4'h9, 0, 0, 16'h9990, 3'd3, 0, 2'd1, 0);
      add(1, 1, 4'h9, 0, 0, 16'h9999, 3'd4, 0, 2'd1, 0);
      add(1, 1, K_EN, 0, 0, 16'h9999, 3'd4, 1, 2'd1, 0);
      add(1, 0, 4'h0, 0, 1, 16'h9999, 3'd4, 0, 2'd0, 1); // third reject -> LOCKED
      add(1, 1, 4'h1, 0, 0, 16'h9999, 3'd4, 0, 2'd0, 1);
      add(0, 0, 4'h0, 0, 0, 16'h9999, 3'd4, 0, 2'd0, 1);
      add(1, 1, K_CN, 1, 1, 16'h9999, 3'd4, 0, 2'd0, 1);

      do_reset();
      check("reset_state", 32'(outs()), 32'(RESET_OUTS));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].card, vecs[i].kv, vecs[i].code, vecs[i].acc, vecs[i].rej);
         check($sformatf("vec%0d", i), 32'(outs()),
               32'({vecs[i].pins, vecs[i].cnt, vecs[i].vld, vecs[i].att,
                    1'b0, 1'b0, vecs[i].lk}));
      end

      // ---------------- timeout 20 cycles after the last key -------------
      do_reset();
      idle();
      key(4'h2);
      key(4'h3);
      first_pulse = 0;
      saw_ej = 1'b0;
      for (int j = 1; j <= 30; j++) begin
         idle();
         if (timeout || eject_card) begin
            first_pulse = j;
            saw_ej = timeout && eject_card;
            break;
         end
      end
      check("timeout_delay", 32'(first_pulse), 32'd20);
      check("timeout_with_eject", 32'(saw_ej), 32'd1);
      check("timeout_digits_cleared", 32'(digit_count), 32'd0);
      step(0, 0, 4'h0, 0, 0);
      check("timeout_single_pulse", 32'({timeout, eject_card}), 32'd0);

      // ---------------- key in the expiring cycle restarts the count ------
      do_reset();
      idle();
      key(4'h2);
      early = 0;
      for (int j = 1; j <= 19; j++) begin
         idle();
         if (timeout) early++;
      end
      key(4'hF);  // the timer reads 19 here, so the key must win
      if (timeout) early++;
      check("late_key_no_timeout", 32'(early), 32'd0);
      check("late_key_digits_kept", 32'(digit_count), 32'd1);
      first_pulse = 0;
      for (int j = 1; j <= 30; j++) begin
         idle();
         if (timeout) begin
            first_pulse = j;
            break;
         end
      end
      check("restart_delay", 32'(first_pulse), 32'd20);

      // ---------------- cancel --------------------------------------------
      do_reset();
      idle();
      key(4'h1);
      key(K_CN);
      check("cancel_eject", 32'({timeout, eject_card}), 32'b01);
      check("cancel_cleared", 32'(digit_count), 32'd0);
      step(0, 0, 4'h0, 0, 0);
      check("cancel_single_pulse", 32'(eject_card), 32'd0);

      // ---------------- card removed while PRESENT -------------------------
      do_reset();
      idle();
      key(4'h4); key(4'h3); key(4'h2); key(4'h1); key(K_EN);
      check("present_valid", 32'(pin_valid), 32'd1);
      step(0, 0, 4'h0, 0, 0);
      check("removal_valid_eject", 32'({pin_valid, eject_card, card_locked}), 32'd0);

      // ---------------- asynchronous reset mid-COLLECT ---------------------
      do_reset();
      idle();
      key(4'h1);
      key(4'h2);
      check("pre_rst_count", 32'(digit_count), 32'd2);
      #2 rst = 1'b1;  // between edges
      #1;
      check("async_reset", 32'(outs()), 32'(RESET_OUTS));
      #1 rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
